fpm_seq_mul: RTL and testbench

- Parametrised, sequential IEEE-754-style floating-point multiplier with a valid/ready handshake on input and output.
- Successor to the combinational single-precision multiplier. Generalised to any exponent/mantissa width.
- Uses an iterative radix-2 shift-add mantissa datapath instead of a full array multiplier.
- Adds correct special-case handling, overflow/underflow saturation, status flags and optional round-to-nearest-even.

---
 rtl/fpm_pkg.sv | 33 +++
 rtl/fpm_classify.sv | 30 +++
 rtl/fpm_seq_mul.sv | 184 ++++++++++++++++++
 tb/tb_fpm_seq_mul.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpm_pkg;
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;
    localparam int EXP_MAX   = (1 << EXP_W_DEF) - 1;
    localparam int FW        = 1 + EXP_W_DEF + MAN_W_DEF;
    localparam int NAN_VW    = 128;

    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_NORM, ST_RND, ST_DONE} state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in a wide vector.
    function automatic logic [NAN_VW-1:0] canon_nan(input int exp_w, input int man_w);
        logic [NAN_VW-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/fpm_classify.sv
// Operand classifier: splits {sign, exp, frac} and tags zero/normal/inf/NaN.
// Latency: combinational; denormals are reported as zero.
// Backpressure: none.
module fpm_classify
    import fpm_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic [1:0]           cls,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       man
);
    logic [MAN_W-1:0] frac;

    always_comb begin
        sign = op[EXP_W+MAN_W];
        exp  = op[MAN_W +: EXP_W];
        frac = op[MAN_W-1:0];
        man  = {1'b1, frac};
        cls  = CLS_NORM;
        if (exp == '0) begin
            cls = CLS_ZERO;
        end else if (exp == '1) begin
            cls = (frac == '0) ? CLS_INF : CLS_NAN;
        end
    end
endmodule

// File: rtl/fpm_seq_mul.sv
// Sequential float multiplier, radix-2 shift-add mantissa; FPM_RNE_EN selects RNE, else truncation.
// Latency: MAN_W+4 cycles to out_valid on the normal path, 1 cycle for special operands.
// Backpressure: one op in flight; in_ready only in IDLE, result held until out_ready.
module fpm_seq_mul
    import fpm_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 flag_ovf,
    output logic                 flag_unf,
    output logic                 flag_inv
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;
    localparam int P2    = 2 * M;
    localparam int CW    = $clog2(M + 1);
    localparam int EW2   = EXP_W + 2;
    localparam int LBIAS = bias_of(EXP_W);
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(exp_max_of(EXP_W));
    localparam logic [NAN_VW-1:0] QNAN_WIDE = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_WIDE[W-1:0];

    state_t state, state_nxt;

    logic [1:0]       cls_a_raw, cls_b_raw;
    cls_t             ca, cb;
    logic             sign_a, sign_b, sgn_ab, special, spec_inv;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [M-1:0]     man_a, man_b;
    logic [W-1:0]     spec_y;

    logic [M-1:0]           ma, mq;
    logic [P2-1:0]          acc;
    logic [M:0]             psum;
    logic [P2-2:0]          nv;
    logic [CW-1:0]          cnt;
    logic                   sgn, grd, stk, rup;
    logic signed [EW2-1:0]  esum, efin;
    logic [MAN_W-1:0]       frac;
    logic [MAN_W:0]         rsum;

    fpm_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(a), .cls(cls_a_raw), .sign(sign_a), .exp(exp_a), .man(man_a)
    );
    fpm_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(b), .cls(cls_b_raw), .sign(sign_b), .exp(exp_b), .man(man_b)
    );

    assign ca      = cls_t'(cls_a_raw);
    assign cb      = cls_t'(cls_b_raw);
    assign sgn_ab  = sign_a ^ sign_b;
    assign special = (ca != CLS_NORM) || (cb != CLS_NORM);

    always_comb begin
        spec_inv = 1'b0;
        spec_y   = {sgn_ab, {(W-1){1'b0}}};
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
            spec_y   = QNAN;
            spec_inv = 1'b1;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            spec_y = {sgn_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Right-shifting shift-add: high half accumulates, low half collects retired bits.
    assign psum = {1'b0, acc[P2-1:M]} + {1'b0, (mq[0] ? ma : {M{1'b0}})};
    // Fraction-aligned product with the hidden bit dropped.
    assign nv   = acc[P2-1] ? acc[P2-2:0] : {acc[P2-3:0], 1'b0};

`ifdef FPM_RNE_EN
    assign rup = grd & (stk | frac[0]);
`else
    logic rnd_unused;
    assign rup        = 1'b0;
    assign rnd_unused = grd ^ stk;
`endif
    assign rsum = {1'b0, frac} + {{MAN_W{1'b0}}, rup};
    assign efin = esum + EW2'(rsum[MAN_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = special ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL:  if (cnt == CW'(1)) state_nxt = ST_NORM;
            ST_NORM: state_nxt = ST_RND;
            ST_RND:  state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inv <= 1'b0;
            ma       <= '0;
            mq       <= '0;
            acc      <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            esum     <= '0;
            frac     <= '0;
            grd      <= 1'b0;
            stk      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    sgn <= sgn_ab;
                    if (special) begin
                        y        <= spec_y;
                        flag_inv <= spec_inv;
                        flag_ovf <= 1'b0;
                        flag_unf <= 1'b0;
                    end else begin
                        ma   <= man_a;
                        mq   <= man_b;
                        acc  <= '0;
                        cnt  <= CW'(M);
                        esum <= {2'b00, exp_a} + {2'b00, exp_b} - EW2'(LBIAS);
                    end
                end
                ST_MUL: begin
                    acc <= {psum, acc[M-1:1]};
                    mq  <= mq >> 1;
                    cnt <= cnt - CW'(1);
                end
                ST_NORM: begin
                    frac <= nv[P2-2 -: MAN_W];
                    grd  <= nv[MAN_W];
                    stk  <= |nv[MAN_W-1:0];
                    if (acc[P2-1]) esum <= esum + EW2'(1);
                end
                ST_RND: begin
                    if (efin >= EMAX_S) begin
                        y        <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flag_ovf <= 1'b1;
                    end else if (efin[EW2-1] || efin == '0) begin
                        y        <= {sgn, {(W-1){1'b0}}};
                        flag_unf <= 1'b1;
                    end else begin
                        y <= {sgn, efin[EXP_W-1:0], rsum[MAN_W-1:0]};
                    end
                end
                ST_DONE: if (out_ready) begin
                    flag_ovf <= 1'b0;
                    flag_unf <= 1'b0;
                    flag_inv <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpm_seq_mul.sv
// Self-checking bench for fpm_seq_mul at the default single-precision format.
// Directed vector table, hand sequences for backpressure and mid-op reset, then random ops vs a model.
module tb_fpm_seq_mul;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        flag_ovf, flag_unf, flag_inv;
    logic [31:0] a, b, y;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vy;
        logic [2:0]  vf;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [2:0]  f;
        int          lat;
    } res_t;

    always #5 clk = ~clk;

    fpm_seq_mul #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: IEEE single multiply from plain integer arithmetic, FTZ, saturating.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] z);
        res_t   r;
        int     ex, ez, e, sh;
        logic   s;
        bit     xn, zn, xi, zi, x0, z0;
        longint p, m;
`ifdef FPM_RNE_EN
        longint rem, half;
`endif
        ex = int'(x[30:23]);
        ez = int'(z[30:23]);
        s  = x[31] ^ z[31];
        xn = (ex == 255) && (x[22:0] != 0);
        zn = (ez == 255) && (z[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        zi = (ez == 255) && (z[22:0] == 0);
        x0 = (ex == 0);
        z0 = (ez == 0);
        r.f   = 3'b000;
        r.lat = 1;
        if (xn || zn || (xi && z0) || (x0 && zi)) begin
            r.y = 32'h7FC00000;
            r.f = 3'b001;
            return r;
        end
        if (xi || zi) begin
            r.y = {s, 8'hFF, 23'h0};
            return r;
        end
        if (x0 || z0) begin
            r.y = {s, 31'h0};
            return r;
        end
        r.lat = 27;
        p  = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, z[22:0]};
        e  = ex + ez - 127;
        sh = 23;
        if (p >= 64'h8000_0000_0000) begin
            sh = 24;
            e++;
        end
        m = p >>> sh;
`ifdef FPM_RNE_EN
        rem  = p - (m <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && m[0])) m++;
        if (m == (64'sd1 <<< 24)) begin
            m = m >>> 1;
            e++;
        end
`endif
        if (e >= 255) begin
            r.y = {s, 8'hFF, 23'h0};
            r.f = 3'b100;
        end else if (e <= 0) begin
            r.y = {s, 31'h0};
            r.f = 3'b010;
        end else begin
            r.y = {s, e[7:0], m[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5)       v[30:23] = 8'($urandom_range(1, 254));
        else if (k < 8)  v[30:23] = 8'($urandom_range(90, 165));
        else if (k == 8) v[30:23] = 8'h00;
        else             v[30:23] = 8'hFF;
        if (k == 9 && v[0]) v[22:0] = '0;
        return v;
    endfunction

    // Starts and ends just after a falling edge; operands held until accepted.
    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input int hold,
                         output logic [31:0] ry, output logic [2:0] rf, output int lat);
        int n;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("result_wait", out_valid, 1);
        ry = y;
        rf = {flag_ovf, flag_unf, flag_inv};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            check("hold_y", y, ry);
            check("hold_flags", {flag_ovf, flag_unf, flag_inv}, rf);
            check("hold_busy", {in_ready, out_valid}, 2'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drained", {out_valid, in_ready}, 2'b01);
        check("flags_cleared", {flag_ovf, flag_unf, flag_inv}, 3'b000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        res_t        r;
        logic [31:0] gy, ra, rb;
        logic [2:0]  gf;
        int          glat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_flags", {flag_ovf, flag_unf, flag_inv}, 3'b000);

        tbl[0] = '{32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 27, 0};
`ifdef FPM_RNE_EN
        tbl[1] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 27, 0};
`else
        tbl[1] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 3'b000, 27, 0};
`endif
        tbl[2] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1, 0};
        tbl[3] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 27, 0};
        tbl[4] = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 27, 0};
        tbl[5] = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000, 3'b000, 27, 5};
        tbl[6] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1, 0};
        tbl[7] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1, 0};
        tbl[8] = '{32'h3F800000, 32'hFFC12345, 32'h7FC00000, 3'b001, 1, 2};

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].va, tbl[i].vb, tbl[i].hold, gy, gf, glat);
            check($sformatf("vec%0d_y", i), gy, tbl[i].vy);
            check($sformatf("vec%0d_flags", i), gf, tbl[i].vf);
            check($sformatf("vec%0d_latency", i), glat, tbl[i].lat);
        end

        // Reset while the mantissa loop is running.
        in_valid = 1'b1;
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mul_busy", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        do_op(32'h3FC00000, 32'h3FC00000, 0, gy, gf, glat);
        check("postrst_y", gy, 32'h40100000);
        check("postrst_flags", gf, 3'b000);
        check("postrst_latency", glat, 27);

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            r  = model(ra, rb);
            do_op(ra, rb, $urandom_range(0, 3), gy, gf, glat);
            check($sformatf("rand%0d_y a=%08h b=%08h", i, ra, rb), gy, r.y);
            check($sformatf("rand%0d_flags", i), gf, r.f);
            check($sformatf("rand%0d_latency", i), glat, r.lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
